// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_mul_seq
// Purpose  : Sequential radix-2 Booth multiplier with signed/unsigned mode.
//            One add/subtract plus one arithmetic right shift per clock.
//            start/busy/done handshake; product register is held until the
//            next completed operation.
// Ports    : clk          - rising-edge clock
//            rst_n        - asynchronous active-low reset
//            start        - operation request (accepted while busy==0)
//            is_signed    - 1: two's-complement operands, 0: unsigned
//            multiplicand - operand M (WIDTH bits)
//            multiplier   - operand Q (WIDTH bits)
//            busy         - high while iterating
//            done         - one-cycle completion pulse
//            product      - 2*WIDTH-bit result register
// Revision : 1.0 - initial release
// ============================================================================
module booth_mul_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Signed operands need WIDTH Booth steps; unsigned ones are treated as
  // non-negative (WIDTH+1)-bit values and therefore need one extra step.
  localparam logic [CNT_W-1:0] C_N_SIGNED   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_N_UNSIGNED = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

  state_e               state_q,   state_d;
  logic [WIDTH:0]       mx_q,      mx_d;
  logic [WIDTH:0]       a_q,       a_d;
  logic [WIDTH:0]       qx_q,      qx_d;
  logic                 qm1_q,     qm1_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic                 sgn_q,     sgn_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // Booth step datapath: A + addend + cin, where subtraction uses ~Mx + 1.
  logic                 w_op_add;
  logic                 w_op_sub;
  logic [WIDTH:0]       w_addend;
  logic [WIDTH:0]       w_cin_vec;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_mx_ext;
  logic [WIDTH:0]       w_qx_ext;

  assign w_op_add  = ~qx_q[0] &  qm1_q;
  assign w_op_sub  =  qx_q[0] & ~qm1_q;
  assign w_addend  = w_op_sub ? ~mx_q : (w_op_add ? mx_q : '0);
  assign w_cin_vec = {{WIDTH{1'b0}}, w_op_sub};
  assign w_sum     = a_q + w_addend + w_cin_vec;

  assign w_mx_ext  = {is_signed & multiplicand[WIDTH-1], multiplicand};
  assign w_qx_ext  = {is_signed & multiplier[WIDTH-1],   multiplier};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mx_q      <= '0;
      a_q       <= '0;
      qx_q      <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mx_q      <= mx_d;
      a_q       <= a_d;
      qx_q      <= qx_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mx_d      = mx_q;
    a_d       = a_q;
    qx_d      = qx_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    product_d = product_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mx_d    = w_mx_ext;
          qx_d    = w_qx_ext;
          a_d     = '0;
          qm1_d   = 1'b0;
          sgn_d   = is_signed;
          cnt_d   = is_signed ? C_N_SIGNED : C_N_UNSIGNED;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        // Arithmetic shift of {A, Qx, q_m1} with A's MSB replicated.
        a_d   = {w_sum[WIDTH], w_sum[WIDTH:1]};
        qx_d  = {w_sum[0], qx_q[WIDTH:1]};
        qm1_d = qx_q[0];
        cnt_d = cnt_q - C_CNT_ONE;
        if (cnt_q == C_CNT_ONE) begin
          state_d = S_DONE;
          // After WIDTH steps (signed) the product sits one bit higher in
          // {A, Qx} than after WIDTH+1 steps (unsigned); Qx[0] then still
          // holds an unconsumed copy of the sign bit.
          if (sgn_q) begin
            product_d = {a_d[WIDTH-1:0], qx_d[WIDTH:1]};
          end else begin
            product_d = {a_d[WIDTH-2:0], qx_d};
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q == S_CALC);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mul_seq
// Purpose  : Self-checking bench for booth_mul_seq (WIDTH=8). Table of
//            directed vectors plus hand-written back-to-back, ignored-start
//            and asynchronous-reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mul_seq;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_checks;
  int n_fail;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           sgn;
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one operation for exactly one sampling edge; returns at the
  // negedge right after that edge (sample index 1).
  task automatic launch(input logic s, input logic [W-1:0] m, input logic [W-1:0] q);
    @(negedge clk);
    is_signed    = s;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  // Sample index counts cycles from the cycle where start was driven (index 0)
  // so a done seen at index N+1 is "N+1 cycles after start".
  task automatic wait_done(input int first_idx, output int idx, output int bcnt);
    idx  = first_idx;
    bcnt = 0;
    while (!done && idx <= 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      idx++;
    end
  endtask

  initial begin
    vec_t vecs[10];
    int   idx;
    int   bcnt;
    int   n_exp;

    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    is_signed    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    vecs[0] = '{1'b1, 8'hFB, 8'h03, 16'hFFF1};  // -5 * 3
    vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};  // -128 * -128
    vecs[2] = '{1'b1, 8'h7F, 8'h80, 16'hC080};  // 127 * -128
    vecs[3] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};  // 255 * 255
    vecs[4] = '{1'b0, 8'h00, 8'hA5, 16'h0000};  // 0 * 165
    vecs[5] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};  // -1 * -1
    vecs[6] = '{1'b0, 8'h80, 8'h80, 16'h4000};  // 128 * 128
    vecs[7] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};  // 127 * 127
    vecs[8] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};  // -1 * 1
    vecs[9] = '{1'b0, 8'h0F, 8'h11, 16'h00FF};  // 15 * 17

    #3;
    chk("reset_busy",    32'(busy),    32'd0);
    chk("reset_done",    32'(done),    32'd0);
    chk("reset_product", 32'(product), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      n_exp = vecs[i].sgn ? W : W + 1;
      launch(vecs[i].sgn, vecs[i].m, vecs[i].q);
      wait_done(1, idx, bcnt);
      chk($sformatf("vec%0d_done_latency", i), 32'(idx), 32'(n_exp + 1));
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(n_exp));
      chk($sformatf("vec%0d_product", i), 32'(product), 32'(vecs[i].exp));
      @(negedge clk);
      chk($sformatf("vec%0d_done_single", i), 32'(done), 32'd0);
      chk($sformatf("vec%0d_product_held", i), 32'(product), 32'(vecs[i].exp));
    end

    // start pulsed mid-CALC with different operands must be ignored.
    launch(1'b1, 8'h0B, 8'h0D);                 // 11 * 13 = 143
    @(negedge clk);
    @(negedge clk);                             // sample index 3
    is_signed    = 1'b0;
    multiplicand = 8'h11;
    multiplier   = 8'h22;
    start        = 1'b1;
    chk("ignore_busy", 32'(busy), 32'd1);
    chk("ignore_product_before", 32'(product), 32'h00FF);
    @(negedge clk);                             // sample index 4
    start = 1'b0;
    chk("ignore_product_still", 32'(product), 32'h00FF);
    wait_done(4, idx, bcnt);
    chk("ignore_done_latency", 32'(idx), 32'(W + 1));
    chk("ignore_product", 32'(product), 32'h008F);
    @(negedge clk);

    // Back-to-back: start held high, next operands already waiting in DONE.
    @(negedge clk);
    is_signed    = 1'b1;
    multiplicand = 8'h07;
    multiplier   = 8'h06;
    start        = 1'b1;
    @(negedge clk);                             // sample index 1
    multiplicand = 8'h0C;
    multiplier   = 8'hF4;
    wait_done(1, idx, bcnt);
    chk("b2b_first_latency", 32'(idx), 32'(W + 1));
    chk("b2b_first_product", 32'(product), 32'h002A);
    @(negedge clk);
    chk("b2b_no_idle_busy", 32'(busy), 32'd1);
    chk("b2b_no_idle_done", 32'(done), 32'd0);
    start = 1'b0;
    wait_done(1, idx, bcnt);
    chk("b2b_second_spacing", 32'(idx), 32'(W + 1));
    chk("b2b_second_product", 32'(product), 32'hFF70);
    @(negedge clk);

    // Asynchronous reset during the fourth iteration of 100 * 100.
    launch(1'b1, 8'h64, 8'h64);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",    32'(busy),    32'd0);
    chk("arst_done",    32'(done),    32'd0);
    chk("arst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(1'b1, 8'h64, 8'h64);
    wait_done(1, idx, bcnt);
    chk("after_rst_latency", 32'(idx), 32'(W + 1));
    chk("after_rst_product", 32'(product), 32'h2710);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
